// File: rtl/apb_master_q.sv
// apb_master_q: APB4 requester fed by a command FIFO.
//
// Commands (read/write, address, data, strobes) are pushed through a
// valid/ready port into a first-word-fall-through FIFO. A four-state FSM
// pops one command at a time and runs a SETUP/ACCESS transfer. ACCESS
// supports wait states and an optional watchdog. The result (read data,
// error and timeout flags) is returned through a valid/ready port.
//
// Handshakes: a transfer on either port happens on a rising PCLK edge
// where valid and ready are both high. A command is held by the sender
// until accepted. A response is held by this block, unchanged, until
// accepted.
//
// Ports:
//   PCLK, PRESET        clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake; ready = FIFO not full
//   cmd_write/addr/wdata/strb   command payload
//   rsp_valid/ready     response handshake
//   rsp_rdata/err/timeout       response payload (rdata is 0 for writes)
//   fifo_level          commands currently queued
//   fsm_state           debug view of the transfer FSM (IDLE=0)
//   PSEL..PSTRB         APB request outputs, all registered
//   PRDATA/PREADY/PSLVERR       APB completer inputs
//
// DATA_W must be 8, 16 or 32. DEPTH must be a power of 2 and at least 2.
// TIMEOUT = 0 disables the watchdog.
module apb_master_q #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [DATA_W-1:0]         cmd_wdata,
   input  logic [DATA_W/8-1:0]       cmd_strb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [1:0]                fsm_state,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   output logic [DATA_W/8-1:0]       PSTRB,
   input  logic [DATA_W-1:0]         PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

   state_t              state;
   logic [CNT_W-1:0]    wait_cnt;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    level_next;
   logic                push;
   logic                pop;

   logic [ADDR_W-1:0]   mem_addr  [DEPTH];
   logic [DATA_W-1:0]   mem_wdata [DEPTH];
   logic [STRB_W-1:0]   mem_strb  [DEPTH];
   logic                mem_write [DEPTH];

   assign fsm_state = state;

   // cmd_ready is a register, so a full FIFO refuses a push even in a
   // cycle where the FSM pops.
   assign push = cmd_valid && cmd_ready;
   assign pop  = (state == IDLE) && (fifo_level != '0);

   always_comb begin
      level_next = fifo_level;
      if (push && !pop) begin
         level_next = fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
         level_next = fifo_level - LVL_W'(1);
      end
   end

   // Payload storage carries no reset; only pointers and level define
   // which entries are valid.
   always_ff @(posedge PCLK) begin
      if (push) begin
         mem_addr[wr_ptr]  <= cmd_addr;
         mem_wdata[wr_ptr] <= cmd_wdata;
         mem_strb[wr_ptr]  <= cmd_strb;
         mem_write[wr_ptr] <= cmd_write;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
      end else begin
         fifo_level <= level_next;
         cmd_ready  <= (level_next != FULL_LVL);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

         case (state)
            IDLE: begin
               if (pop) begin
                  PADDR  <= mem_addr[rd_ptr];
                  PWRITE <= mem_write[rd_ptr];
                  // Reads never present write data or strobes on the bus.
                  PWDATA <= mem_write[rd_ptr] ? mem_wdata[rd_ptr] : '0;
                  PSTRB  <= mem_write[rd_ptr] ? mem_strb[rd_ptr] : '0;
                  PSEL   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  state       <= RESP;
               end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                  // wait_cnt counts ACCESS cycles already spent, so the
                  // abort lands at the end of the TIMEOUT-th cycle.
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_q.sv
// Bench for apb_master_q: directed scenarios with literal expectations,
// then a randomized run. A behavioural model of queued commands and
// transfer timing is checked against the DUT on every falling edge.
module tb_apb_master_q;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int SW      = DW / 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int LW      = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;
   always #5 PCLK = ~PCLK;

   logic           cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0]  cmd_addr;
   logic [DW-1:0]  cmd_wdata;
   logic [SW-1:0]  cmd_strb;
   logic           rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0]  rsp_rdata;
   logic [LW-1:0]  fifo_level;
   logic [1:0]     fsm_state;
   logic           PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0]  PADDR;
   logic [DW-1:0]  PWDATA, PRDATA;
   logic [SW-1:0]  PSTRB;

   apb_master_q #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .fifo_level(fifo_level),
      .fsm_state(fsm_state),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- APB completer ----------------
   // mode 0: directed waits/err/rdata; 1: zero waits, rdata = addr*3+1;
   // 2: random waits (sometimes never ready), random PRDATA/PSLVERR per cycle.
   int            slv_mode  = 0;
   int            slv_waits = 0;
   logic          slv_err   = 1'b0;
   logic [DW-1:0] slv_rdata = '0;

   initial begin
      int   cur_waits;
      int   k;
      logic cur_err;
      cur_waits = 0;
      k         = 0;
      cur_err   = 1'b0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      forever begin
         @(posedge PCLK);
         #1;
         if (PSEL && !PENABLE) begin
            k = 0;
            case (slv_mode)
               0: begin cur_waits = slv_waits; cur_err = slv_err; end
               1: begin cur_waits = 0; cur_err = 1'b0; end
               default: begin
                  cur_waits = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 3);
                  cur_err   = 1'b0;
               end
            endcase
         end
         if (slv_mode == 2) begin
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
         end else begin
            PRDATA  = (slv_mode == 1) ? (PADDR * 32'd3 + 32'd1) : slv_rdata;
            PSLVERR = cur_err;
         end
         if (PSEL && PENABLE) begin
            PREADY = (k >= cur_waits);
            k++;
         end else begin
            PREADY = 1'b0;
         end
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
   } cmd_t;

   cmd_t          m_q[$];       // commands accepted but not yet started
   cmd_t          m_cur;        // command on the bus
   int            m_age = -1;   // cycles since transfer start: -1 none, 0 setup, n>=1 n-th access cycle
   logic          m_rsp = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_err = 1'b0;
   logic          m_to = 1'b0;
   logic          m_rdy_ok = 1'b0;   // cmd_ready allowed: at least one edge since reset
   int            m_rsp_count = 0;

   initial begin
      forever begin
         @(negedge PCLK);
         if (PRESET) begin
            m_q.delete();
            m_age    = -1;
            m_rsp    = 1'b0;
            m_rdy_ok = 1'b0;
            chk("rst_psel", 64'(PSEL), 64'd0);
            chk("rst_penable", 64'(PENABLE), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("rst_fifo_level", 64'(fifo_level), 64'd0);
            chk("rst_fsm_state", 64'(fsm_state), 64'd0);
            chk("rst_paddr", 64'(PADDR), 64'd0);
            chk("rst_pwdata", 64'(PWDATA), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err), 64'd0);
         end else begin
            logic do_push;
            chk("cmd_ready", 64'(cmd_ready), 64'(m_rdy_ok && (m_q.size() != DEPTH)));
            chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
            chk("psel", 64'(PSEL), 64'(m_age >= 0));
            chk("penable", 64'(PENABLE), 64'(m_age >= 1));
            if (m_age >= 0) begin
               chk("paddr", 64'(PADDR), 64'(m_cur.addr));
               chk("pwrite", 64'(PWRITE), 64'(m_cur.wr));
               chk("pwdata", 64'(PWDATA), 64'(m_cur.wr ? m_cur.wdata : '0));
               chk("pstrb", 64'(PSTRB), 64'(m_cur.wr ? m_cur.strb : '0));
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
            if (m_rsp) begin
               chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
               chk("rsp_err", 64'(rsp_err), 64'(m_err));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
            end

            // advance to the next cycle using the inputs now applied
            do_push = cmd_valid && m_rdy_ok && (m_q.size() != DEPTH);
            if (m_rsp) begin
               if (rsp_ready) begin
                  m_rsp = 1'b0;
                  m_rsp_count++;
               end
            end else if (m_age < 0) begin
               if (m_q.size() > 0) begin
                  m_cur = m_q.pop_front();
                  m_age = 0;
               end
            end else if (PREADY && m_age >= 1) begin
               m_rsp   = 1'b1;
               m_rdata = m_cur.wr ? '0 : PRDATA;
               m_err   = PSLVERR;
               m_to    = 1'b0;
               m_age   = -1;
            end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
               m_rsp   = 1'b1;
               m_rdata = '0;
               m_err   = 1'b1;
               m_to    = 1'b1;
               m_age   = -1;
            end else begin
               m_age++;
            end
            if (do_push) m_q.push_back({cmd_write, cmd_addr, cmd_wdata, cmd_strb});
            m_rdy_ok = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   // Entered and left just after a rising edge; the edge that accepts the
   // command is the last one passed.
   task automatic push_one(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output logic acc);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      @(negedge PCLK);
      acc = cmd_ready;
      @(posedge PCLK);
      #1;
      cmd_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic acc;
      int   n_acc;
      int   idx;
      int   pcts[6];
      logic done;
      pcts = '{90, 10, 60, 100, 30, 80};
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b1;

      // reset state
      cyc(1);
      chk("init_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("init_psel", 64'(PSEL), 64'd0);
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
      cyc(1);
      chk("ready_before_edge", 64'(cmd_ready), 64'd0);
      cyc(1);
      chk("ready_after_edge", 64'(cmd_ready), 64'd1);
      @(posedge PCLK);
      #1;

      // single write, zero wait states
      slv_mode = 0; slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'h0BAD_0BAD;
      push_one(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
      chk("wr_accept", 64'(acc), 64'd1);
      cyc(1); chk("wr_n_psel", 64'(PSEL), 64'd0);
      cyc(1); chk("wr_n1_psel", 64'(PSEL), 64'd1);
              chk("wr_n1_penable", 64'(PENABLE), 64'd0);
      cyc(1); chk("wr_n2_penable", 64'(PENABLE), 64'd1);
              chk("wr_n2_paddr", 64'(PADDR), 64'h10);
              chk("wr_n2_pwdata", 64'(PWDATA), 64'hDEADBEEF);
              chk("wr_n2_pstrb", 64'(PSTRB), 64'hF);
      cyc(1); chk("wr_n3_rsp_valid", 64'(rsp_valid), 64'd1);
              chk("wr_n3_rsp_err", 64'(rsp_err), 64'd0);
              chk("wr_n3_rsp_rdata", 64'(rsp_rdata), 64'd0);
              chk("wr_n3_psel", 64'(PSEL), 64'd0);
      @(posedge PCLK); #1;

      // read with three wait states
      slv_waits = 3; slv_rdata = 32'h12345678;
      push_one(1'b0, 32'h24, 32'hFFFF_FFFF, 4'hF, acc);
      cyc(2); chk("rd_n1_pstrb", 64'(PSTRB), 64'd0);
              chk("rd_n1_pwdata", 64'(PWDATA), 64'd0);
      cyc(4); chk("rd_n5_penable", 64'(PENABLE), 64'd1);
              chk("rd_n5_pstrb", 64'(PSTRB), 64'd0);
              chk("rd_n5_rsp_valid", 64'(rsp_valid), 64'd0);
      cyc(1); chk("rd_n6_rsp_valid", 64'(rsp_valid), 64'd1);
              chk("rd_n6_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
      @(posedge PCLK); #1;

      // slave error
      slv_waits = 0; slv_err = 1'b1;
      push_one(1'b1, 32'h88, 32'h5555_AAAA, 4'h3, acc);
      cyc(4); chk("err_rsp_valid", 64'(rsp_valid), 64'd1);
              chk("err_rsp_err", 64'(rsp_err), 64'd1);
              chk("err_rsp_timeout", 64'(rsp_timeout), 64'd0);
      @(posedge PCLK); #1;

      // watchdog timeout
      slv_waits = 1000; slv_err = 1'b0; slv_rdata = 32'hCAFEF00D;
      push_one(1'b0, 32'h30, 32'h0, 4'h0, acc);
      cyc(18); chk("to_n17_penable", 64'(PENABLE), 64'd1);
               chk("to_n17_rsp_valid", 64'(rsp_valid), 64'd0);
      cyc(1);  chk("to_n18_rsp_valid", 64'(rsp_valid), 64'd1);
               chk("to_n18_rsp_err", 64'(rsp_err), 64'd1);
               chk("to_n18_rsp_timeout", 64'(rsp_timeout), 64'd1);
               chk("to_n18_rsp_rdata", 64'(rsp_rdata), 64'd0);
               chk("to_n18_psel", 64'(PSEL), 64'd0);
      @(posedge PCLK); #1;

      // FIFO full with responses held back
      slv_mode = 1;
      rsp_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         push_one(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, acc);
         if (acc) n_acc++;
      end
      cyc(1);
      chk("full_accepted", 64'(n_acc), 64'd5);
      chk("full_level", 64'(fifo_level), 64'd4);
      chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge PCLK); #1;
      rsp_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 100 && idx < 5; c++) begin
         @(negedge PCLK);
         if (rsp_valid && rsp_ready) begin
            chk($sformatf("full_order_%0d", idx), 64'(rsp_rdata),
                64'((32'h100 + 32'(idx * 4)) * 32'd3 + 32'd1));
            idx++;
         end
      end
      chk("full_rsp_count", 64'(idx), 64'd5);
      @(posedge PCLK); #1;
      cyc(2);
      @(posedge PCLK); #1;

      // reset in the middle of ACCESS
      slv_mode = 0; slv_waits = 5; slv_err = 1'b0; slv_rdata = 32'h7777_0000;
      push_one(1'b0, 32'h40, 32'h0, 4'h0, acc);
      push_one(1'b1, 32'h44, 32'h1111_2222, 4'hF, acc);
      cyc(2);
      chk("mid_penable", 64'(PENABLE), 64'd1);
      chk("mid_level", 64'(fifo_level), 64'd1);
      #2 PRESET = 1'b1;
      #1;
      chk("arst_psel", 64'(PSEL), 64'd0);
      chk("arst_penable", 64'(PENABLE), 64'd0);
      chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("arst_level", 64'(fifo_level), 64'd0);
      @(negedge PCLK);
      @(posedge PCLK);
      #1 PRESET = 1'b0;
      cyc(1); chk("post_rst_ready0", 64'(cmd_ready), 64'd0);
      cyc(1); chk("post_rst_ready1", 64'(cmd_ready), 64'd1);
              chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      @(posedge PCLK); #1;
      slv_waits = 0;
      push_one(1'b1, 32'h50, 32'hA5A5_5A5A, 4'h9, acc);
      cyc(4); chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
              chk("post_rst_rsp_err", 64'(rsp_err), 64'd0);
      @(posedge PCLK); #1;

      // randomized traffic, varying response back-pressure
      slv_mode = 2;
      for (int c = 0; c < 600; c++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         cmd_strb  = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 99) < pcts[(c / 100) % 6]);
         @(posedge PCLK);
         #1;
      end

      // drain
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge PCLK);
         done = (m_q.size() == 0) && (m_age < 0) && !m_rsp;
      end
      chk("drain_done", 64'(done), 64'd1);
      chk("drain_level", 64'(fifo_level), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // global bound
   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/apb_master_q.md
Name: apb_master_q

Overview:
- Synthesizable, parametrised APB4 requester. It replaces the task-driven bench master with RTL that can sit in both the design and the testbench.
- Accepts read/write commands through a valid/ready port and buffers them in an internal command FIFO.
- Executes each command as a standard APB SETUP/ACCESS transfer, with wait-state support and a watchdog timeout.
- Returns one response per command (read data, error flag, timeout flag) through a valid/ready port.

Parameters:
ADDR_W, 32, PADDR and cmd_addr width
DATA_W, 32, PWDATA/PRDATA width; must be 8, 16 or 32
DEPTH, 4, command FIFO entries; power of 2, >= 2
TIMEOUT, 16, ACCESS cycles without PREADY before abort; 0 disables the watchdog

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by watchdog
fifo_level  out  $clog2(DEPTH)+1  entries held in the FIFO
PSEL, PENABLE, PWRITE  out  1  APB control
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset: PRESET high clears all outputs to 0 immediately, independent of PCLK.
  - FIFO is emptied and the FSM returns to IDLE.
  - An in-flight transfer is dropped with no response.
  - cmd_ready rises on the first PCLK edge after PRESET deasserts.
- Command push: a command is pushed when cmd_valid && cmd_ready on a PCLK edge.
  - cmd_ready = (fifo_level != DEPTH).
  - cmd_ready does not depend on pop, so a full FIFO blocks push even in a cycle that pops.
- FIFO behaviour:
  - Read/write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - The FIFO is first-word-fall-through.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If the FIFO is non-empty: pop the head, register PADDR/PWRITE/PWDATA/PSTRB, go to SETUP.
  - On reads, PSTRB=0 and PWDATA=0.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS. Timeout counter is cleared.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB stay stable for the whole transfer.
  - If PREADY=1: capture PRDATA (reads only), set rsp_err=PSLVERR and rsp_timeout=0, go to RESP.
  - Otherwise the counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY still 0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1. Response fields are held until rsp_ready.
  - When rsp_valid && rsp_ready: go to IDLE. No new transfer starts while a response is pending.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE gives:
  - SETUP during cycle N+1, ACCESS during N+2.
  - With zero wait states, rsp_valid at N+3.
  - Each wait state adds 1 cycle.
  - With rsp_ready held high, back-to-back transfers start every 4 cycles.
- Output rule: APB outputs are driven from registers only; there are no combinational paths from PREADY to APB outputs.

Test Plan:
- Single write: cmd write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL at N+1, PENABLE at N+2 with PADDR=0x10 and PWDATA=0xDEADBEEF; rsp_valid at N+3 with rsp_err=0.
- Read with 3 wait states: addr 0x24, PRDATA=0x12345678 with PREADY low for 3 ACCESS cycles -> rsp_valid at N+6, rsp_rdata=0x12345678, PSTRB=0 throughout.
- Slave error: write with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16 with PREADY held 0 -> ACCESS lasts 16 cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL drops.
- FIFO full/backpressure: DEPTH=4, rsp_ready=0, push 6 commands -> 5 accepted (1 in flight, 4 queued), cmd_ready=0, fifo_level=4. Release rsp_ready -> responses arrive in push order.
- Reset mid-ACCESS: assert PRESET between edges -> PSEL, PENABLE and rsp_valid go 0 asynchronously, fifo_level=0, no response; the next command completes normally.
